fifo_rd_burst_sched: RTL
========================

Name: fifo_rd_burst_sched

Overview:
- Read-domain scheduler that shares the async FIFO read port between NUM_REQ consumers.
- Grants one requester at a time, round-robin, for a burst of req_len words.
- Drives the FIFO rd_en from the empty flag and a one-entry registered output stage with valid/ready handshake.
- Sits between the FIFO read-pointer/empty logic plus memory read port and the downstream consumers.

Parameters:
- DATA_W, 8, FIFO word width.
- NUM_REQ, 2, number of requesters (2..8).
- LEN_W, 4, burst-length field width; max burst is 2^LEN_W words.

Ports:
- rd_clk  in  1  read-domain clock
- rd_rst  in  1  reset, asynchronous, active-low
- req  in  NUM_REQ  per-requester burst request, level
- req_len  in  NUM_REQ*LEN_W  burst length per requester, slice i = [i*LEN_W +: LEN_W]; 0 means 2^LEN_W
- gnt  out  NUM_REQ  one-hot grant, held for the whole burst
- fifo_empty  in  1  FIFO empty flag (read domain)
- fifo_rd_data  in  DATA_W  head word, first-word-fall-through, valid while !fifo_empty
- fifo_rd_en  out  1  pop strobe to FIFO read-pointer logic
- out_valid  out  1  output word valid
- out_data  out  DATA_W  output word
- out_id  out  $clog2(NUM_REQ)  index of the granted requester owning out_data
- out_ready  in  1  consumer accepts out_data
- done  out  NUM_REQ  one-cycle pulse on the granted bit after the last word of a burst is accepted
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset values: state IDLE, gnt=0, fifo_rd_en=0, out_valid=0, out_data=0, out_id=0, done=0, busy=0, rr pointer=0, remaining=0.
- Reset asserted mid-burst aborts immediately. Any word held in the output stage is discarded and the grant is released.
- States: IDLE, BURST, DRAIN.
- IDLE, entry:
  - If any req bit is set, pick the first set bit at or after rr_ptr (wrapping).
  - Register gnt (one-hot), out_id and remaining = req_len of the winner (0 loads 2^LEN_W; remaining is LEN_W+1 bits).
  - Go to BURST. Grant is visible the cycle after req is seen.
- IDLE, hold: no req means stay in IDLE.
- fifo_rd_en is combinational: (state==BURST) & !fifo_empty & (remaining!=0) & (!out_valid | out_ready). It is never asserted in IDLE or DRAIN.
- Pop cycle (fifo_rd_en=1): out_data <= fifo_rd_data, out_valid <= 1, remaining decrements. This gives one-cycle latency from pop to out_valid.
- Handshake without pop (out_valid & out_ready & !fifo_rd_en): out_valid <= 0.
- out_data and out_id are stable while out_valid & !out_ready.
- Sustained throughput is 1 word/cycle with out_ready held high.
- BURST -> DRAIN when a pop takes remaining to 0.
- DRAIN: wait for the final handshake (out_valid & out_ready). On that edge go to IDLE, pulse done[granted], clear gnt, and set rr_ptr = granted index + 1 (mod NUM_REQ).
- Single-word burst (len 1): BURST lasts one pop cycle, then DRAIN.
- FIFO empty mid-burst: the scheduler stalls in BURST with no pop. The burst is never abandoned and the grant is held.
- req deassert mid-burst is ignored; the burst completes. req sampled in IDLE only.
- A requester re-requesting at done gets its turn only after all other pending requesters (round-robin fairness).
- A new grant is possible the cycle after done, so there is one idle cycle between bursts.
- The fifo_empty value at reset is not trusted: no pop occurs before a grant exists.

Decomposition:
- Package fifo_rd_sched_pkg holds:
  - state enum {IDLE, BURST, DRAIN}
  - localparam ID_W = $clog2(NUM_REQ)
  - function len_decode (0 -> 2^LEN_W)
- Sub-module rr_arbiter: combinational round-robin pick from req and rr_ptr, giving a one-hot grant and an index. Reusable for the write-side scheduler.

Test Plan:
- Single burst: FIFO preloaded with 0x10..0x13, req[0]=1, len=4, out_ready=1 -> gnt=01 next cycle; out_data 0x10,0x11,0x12,0x13 on consecutive cycles with out_id=0; done[0] pulses once after 0x13 accepted; exactly 4 fifo_rd_en pulses.
- Backpressure: same burst, out_ready low for 3 cycles after first word -> out_data holds 0x10, fifo_rd_en=0 during stall; order and count preserved.
- Underflow stall: FIFO holds 2 words, len=4 -> 2 words out, then fifo_rd_en=0 and gnt held; write 2 more words -> burst completes, done pulses.
- Round-robin: req=11 constantly, len 2 each -> grant order 0,1,0,1 with out_id matching; no requester granted twice in a row.
- Length zero: LEN_W=4, len=0 -> exactly 16 words popped before done.
- Reset mid-burst: drop rd_rst after 2 of 4 words -> all outputs return to reset values asynchronously; after release, a new req is granted from rr_ptr=0.

Source files
------------

// File: rtl/fifo_rd_sched_pkg.sv
// Shared types and helpers for the FIFO read/write burst schedulers.
package fifo_rd_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int unsigned DEF_DATA_W  = 8;
  localparam int unsigned DEF_NUM_REQ = 2;
  localparam int unsigned DEF_LEN_W   = 4;
  localparam int unsigned ID_W        = $clog2(DEF_NUM_REQ);
  localparam int unsigned MAX_LEN_W   = 16;

  // A zero length field stands for the largest burst, 2^len_w words.
  function automatic logic [MAX_LEN_W:0] len_decode(input logic [MAX_LEN_W-1:0] len,
                                                    input int unsigned len_w);
    if (len == '0) return (MAX_LEN_W+1)'(1) << len_w;
    return {1'b0, len};
  endfunction

endpackage

// File: rtl/fifo_rd_burst_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter
  import fifo_rd_sched_pkg::*;
#(
  parameter int unsigned N     = DEF_NUM_REQ,
  parameter int unsigned IDX_W = ID_W
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt_c,
  output logic [IDX_W-1:0] idx_c,
  output logic             any_c
);

  logic [2*N-1:0] rot;
  int unsigned    sum;

  // Rotating the doubled vector puts requester ptr at bit 0.
  always_comb begin
    rot   = {req, req} >> ptr;
    gnt_c = '0;
    idx_c = '0;
    any_c = 1'b0;
    sum   = 0;
    for (int i = 0; i < int'(N); i++) begin
      if (!any_c && rot[i]) begin
        any_c = 1'b1;
        sum   = 32'(ptr) + 32'(i);
        if (sum >= N) sum = sum - N;
        idx_c = IDX_W'(sum);
      end
    end
    if (any_c) gnt_c = N'(1) << idx_c;
  end

endmodule

// File: rtl/fifo_rd_burst_sched.sv
// Shares the async FIFO read port between requesters, one round-robin burst at a time,
// through a one-entry registered valid/ready output stage.
module fifo_rd_burst_sched
  import fifo_rd_sched_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned LEN_W   = DEF_LEN_W
) (
  input  logic                       rd_clk,
  input  logic                       rd_rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*LEN_W-1:0]   req_len,
  output logic [NUM_REQ-1:0]         gnt,
  input  logic                       fifo_empty,
  input  logic [DATA_W-1:0]          fifo_rd_data,
  output logic                       fifo_rd_en,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(NUM_REQ)-1:0] out_id,
  input  logic                       out_ready,
  output logic [NUM_REQ-1:0]         done,
  output logic                       busy
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = LEN_W + 1;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]   remaining;
  logic [NUM_REQ-1:0] arb_gnt_c;
  logic [IDX_W-1:0]   arb_idx_c;
  logic               arb_any_c;
  logic [LEN_W-1:0]   win_len_c;
  logic               handshake_c;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req   (req),
    .ptr   (rr_ptr),
    .gnt_c (arb_gnt_c),
    .idx_c (arb_idx_c),
    .any_c (arb_any_c)
  );

  // Burst length of the arbitration winner.
  always_comb begin
    win_len_c = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (arb_gnt_c[i]) win_len_c = req_len[i*LEN_W +: LEN_W];
    end
  end

  assign handshake_c = out_valid & out_ready;

  always_ff @(posedge rd_clk or negedge rd_rst) begin
    if (!rd_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  // Pop only while bursting with words left and room in the output stage.
  always_comb begin
    state_nxt  = state;
    fifo_rd_en = 1'b0;
    case (state)
      IDLE: begin
        if (arb_any_c) state_nxt = BURST;
      end
      BURST: begin
        fifo_rd_en = !fifo_empty && (remaining != '0) && (!out_valid || out_ready);
        if (fifo_rd_en && (remaining == CNT_W'(1))) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (handshake_c) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge rd_clk or negedge rd_rst) begin
    if (!rd_rst) begin
      gnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      done      <= '0;
      busy      <= 1'b0;
      rr_ptr    <= '0;
      remaining <= '0;
    end else begin
      done <= '0;
      busy <= (state_nxt != IDLE);
      if ((state == IDLE) && arb_any_c) begin
        gnt       <= arb_gnt_c;
        out_id    <= arb_idx_c;
        remaining <= CNT_W'(len_decode(MAX_LEN_W'(win_len_c), LEN_W));
      end
      if (fifo_rd_en) begin
        out_data  <= fifo_rd_data;
        out_valid <= 1'b1;
        remaining <= remaining - CNT_W'(1);
      end else if (handshake_c) begin
        out_valid <= 1'b0;
      end
      // Last word accepted: release the grant and move priority past the owner.
      if ((state == DRAIN) && handshake_c) begin
        done   <= gnt;
        gnt    <= '0;
        rr_ptr <= (out_id == IDX_W'(NUM_REQ - 1)) ? '0 : out_id + IDX_W'(1);
      end
    end
  end

endmodule
